// File: rtl/blackjack_pkg.sv
// Shared BlackJack definitions: card constants, dealer FSM states and the
// rank-to-points mapping used by the dealer and the scorer.
package blackjack_pkg;

  localparam int CARD_RANKS = 13;
  localparam int MAX_POINTS = 10;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    HOLD
  } state_e;

  // Face cards score 10; an ace is reported as 1 here.
  function automatic logic [3:0] rank_to_points(input logic [3:0] rank);
    return (rank > 4'(MAX_POINTS)) ? 4'(MAX_POINTS) : rank;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Counts enabled 2 kHz ticks and flags the tick that completes HOLD_TICKS.
// Saturates at HOLD_TICKS until the next clear.
module tick_timer #(
  parameter int HOLD_TICKS = 4000
) (
  input  logic clk_50M,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_TickEn,
  output logic o_Done
);

  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0] TERM = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] LAST = CW'(HOLD_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    o_Done = 1'b0;
    if (i_Clear) begin
      cnt_d = '0;
    end else if (i_TickEn && (cnt_q < TERM)) begin
      cnt_d  = cnt_q + CW'(1);
      o_Done = (cnt_q == LAST);
    end
  end

  always_ff @(posedge clk_50M or posedge i_Reset) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/card_dealer.sv
// BlackJack draw unit: reduces a sampled entropy count to a rank 1..13 by
// repeated subtraction, reports rank and points, then holds for HOLD_TICKS.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int HOLD_TICKS = 4000
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_Tick2K,
  input  logic [WIDTH-1:0] i_Entropy,
  input  logic             i_Draw,
  output logic             o_Busy,
  output logic             o_CardValid,
  output logic [3:0]       o_Card,
  output logic [3:0]       o_Points,
  output logic             o_TwoSec
);

  state_e     state_q, state_d;
  logic [5:0] rem_q, rem_d;
  logic [3:0] card_q, card_d;
  logic [3:0] points_q, points_d;
  logic       valid_q, valid_d;
  logic       twosec_q, twosec_d;
  logic       tmr_clear, tmr_en, tmr_done;
  logic [3:0] rank;
  logic       unused_entropy;

  // Only the low six bits feed the reduction.
  assign unused_entropy = ^i_Entropy;
  assign rank           = rem_q[3:0] + 4'd1;

  tick_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_tick_timer (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .i_Clear (tmr_clear),
    .i_TickEn(tmr_en),
    .o_Done  (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    card_d    = card_q;
    points_d  = points_q;
    valid_d   = 1'b0;
    twosec_d  = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Draw) begin
          rem_d   = i_Entropy[5:0];
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (rem_q >= 6'(CARD_RANKS)) begin
          rem_d = rem_q - 6'(CARD_RANKS);
        end else begin
          card_d    = rank;
          points_d  = rank_to_points(rank);
          valid_d   = 1'b1;
          tmr_clear = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        tmr_en = i_Tick2K;
        if (tmr_done) begin
          twosec_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      card_q   <= '0;
      points_q <= '0;
      valid_q  <= 1'b0;
      twosec_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      card_q   <= card_d;
      points_q <= points_d;
      valid_q  <= valid_d;
      twosec_q <= twosec_d;
    end
  end

  assign o_Busy      = (state_q != IDLE);
  assign o_CardValid = valid_q;
  assign o_Card      = card_q;
  assign o_Points    = points_q;
  assign o_TwoSec    = twosec_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with a short hold so full draws fit in a
// few dozen cycles.
module tb_card_dealer;

  localparam int WIDTH = 12;
  localparam int HOLD  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic             draw;
  logic [WIDTH-1:0] ent;
  logic             busy, cvalid, twosec;
  logic [3:0]       card, points;

  int n_cmp = 0;
  int n_bad = 0;

  card_dealer #(
    .WIDTH(WIDTH),
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk_50M    (clk),
    .i_Reset    (rst),
    .i_Tick2K   (tick),
    .i_Entropy  (ent),
    .i_Draw     (draw),
    .o_Busy     (busy),
    .o_CardValid(cvalid),
    .o_Card     (card),
    .o_Points   (points),
    .o_TwoSec   (twosec)
  );

  always #10 clk = ~clk;

  typedef struct {
    int e;
    int card;
    int pts;
    bit tick_last;
    bit poke;
    bit held;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int  c;
    bit  got;
    c = 0;
    got = 1'b0;
    while (!got && c < 200) begin
      tick = (c % 5 == 0);
      step();
      tick = 1'b0;
      got = twosec;
      c++;
    end
    check("drain_done", int'(got), 1);
    step();
  endtask

  task automatic run_draw(input vec_t v);
    int cyc, c, ticks, extra, n;
    bit got;
    n = v.e / 13;
    ent = {6'h2A, 6'(v.e)};
    draw = 1'b1;
    step();
    if (!v.held) draw = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick = v.tick_last && (cyc == n);
      if (v.poke && cyc == 1) draw = 1'b1;
      step();
      tick = 1'b0;
      if (!v.held) draw = 1'b0;
      cyc++;
      got = cvalid;
    end
    check("valid_latency", got ? cyc : -1, n + 1);
    check("card", int'(card), v.card);
    check("points", int'(points), v.pts);
    check("busy_in_hold", int'(busy), 1);
    step();
    check("valid_one_cycle", int'(cvalid), 0);
    ticks = 0;
    extra = 0;
    got = 1'b0;
    c = 0;
    while (!got && c < 100) begin
      tick = (c % 5 == 0);
      if (v.poke && c == 2) draw = 1'b1;
      step();
      if (tick) ticks++;
      tick = 1'b0;
      if (!v.held) draw = 1'b0;
      extra += int'(cvalid);
      got = twosec;
      c++;
    end
    check("twosec_ticks", got ? ticks : -1, HOLD);
    check("busy_at_twosec", int'(busy), 0);
    check("no_extra_valid", extra, 0);
    check("card_held", int'(card), v.card);
    step();
    check("twosec_one_cycle", int'(twosec), 0);
    if (v.held) begin
      check("held_reaccept", int'(busy), 1);
      draw = 1'b0;
      drain();
    end else begin
      check("no_queued_draw", int'(busy), 0);
    end
  endtask

  initial begin
    int ts;
    vec_t v;
    vecs[0] = '{e: 0,  card: 1,  pts: 1,  tick_last: 1'b1, poke: 1'b0, held: 1'b0};
    vecs[1] = '{e: 63, card: 12, pts: 10, tick_last: 1'b0, poke: 1'b1, held: 1'b0};
    vecs[2] = '{e: 9,  card: 10, pts: 10, tick_last: 1'b0, poke: 1'b0, held: 1'b0};
    vecs[3] = '{e: 10, card: 11, pts: 10, tick_last: 1'b0, poke: 1'b0, held: 1'b0};
    vecs[4] = '{e: 25, card: 13, pts: 10, tick_last: 1'b0, poke: 1'b0, held: 1'b0};
    vecs[5] = '{e: 50, card: 12, pts: 10, tick_last: 1'b1, poke: 1'b0, held: 1'b1};

    rst  = 1'b1;
    tick = 1'b0;
    draw = 1'b0;
    ent  = '0;
    step();
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(cvalid), 0);
    check("rst_card", int'(card), 0);
    check("rst_points", int'(points), 0);
    check("rst_twosec", int'(twosec), 0);
    rst = 1'b0;
    step();
    step();
    check("idle_no_draw", int'(busy), 0);

    for (int i = 0; i < 6; i++) run_draw(vecs[i]);

    // Reset in the middle of HOLD after two counted ticks.
    ent  = 12'd3;
    draw = 1'b1;
    step();
    draw = 1'b0;
    step();
    check("mid_card", int'(card), 4);
    tick = 1'b1; step(); tick = 1'b0; step();
    tick = 1'b1; step(); tick = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(cvalid), 0);
    check("arst_card", int'(card), 0);
    check("arst_points", int'(points), 0);
    check("arst_twosec", int'(twosec), 0);
    step();
    rst = 1'b0;
    ts = 0;
    for (int c = 0; c < 30; c++) begin
      tick = (c % 5 == 0);
      step();
      tick = 1'b0;
      ts += int'(twosec);
    end
    check("no_twosec_after_abort", ts, 0);
    check("idle_after_abort", int'(busy), 0);
    v = '{e: 14, card: 2, pts: 2, tick_last: 1'b0, poke: 1'b0, held: 1'b0};
    run_draw(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
